// File: rtl/csa_resolve_pkg.sv
// Shared types and defaults for the carry-save resolve adder.
// FSM state encoding plus default operand / segment widths.
// Imported by the top level; holds no logic.
package csa_resolve_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SEG   = 16;

endpackage

// File: rtl/cpa_segment.sv
// One SEG-bit slice of the carry-propagate adder: s = a + b + cin.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owning FSM decides when the result is used.
module cpa_segment #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  // One extra bit holds the carry out of the slice.
  logic [SEG:0] total;

  assign total = {1'b0, a} + {1'b0, b} + (SEG+1)'(cin);
  assign s     = total[SEG-1:0];
  assign cout  = total[SEG];

endmodule

// File: rtl/csa_resolve_adder.sv
// Resolves a carry-save (S, C) pair into binary, one SEG-bit segment per cycle.
// Latency: out_valid rises NSEG cycles after the accept edge.
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready.
module csa_resolve_adder
  import csa_resolve_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int NSEG = WIDTH / SEG;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NSEG - 1);

  // A width that is not a whole number of segments would leave top bits unresolved.
  if (WIDTH % SEG != 0) begin : g_bad_width
    $error("csa_resolve_adder: WIDTH must be a multiple of SEG");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] s_reg_q, s_reg_d;
  logic [WIDTH-1:0] c_reg_q, c_reg_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  logic [SEG-1:0]   seg_a, seg_b, seg_s;
  logic             seg_cout;
  int               seg_base;

  // Ready is a pure state decode so upstream sees no combinational loop.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

  // Select the operand slice for the current segment into the single shared adder.
  always_comb begin
    seg_base = int'(k_q) * SEG;
    seg_a    = s_reg_q[seg_base +: SEG];
    seg_b    = c_reg_q[seg_base +: SEG];
  end

  cpa_segment #(.SEG(SEG)) u_seg (
    .a    (seg_a),
    .b    (seg_b),
    .cin  (cy_q),
    .s    (seg_s),
    .cout (seg_cout)
  );

  // Next-state logic: capture operands, walk the segments, then hold the result.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cy_d        = cy_q;
    s_reg_d     = s_reg_q;
    c_reg_d     = c_reg_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          s_reg_d = s_in;
          c_reg_d = c_in;
          cy_d    = 1'b0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[seg_base +: SEG] = seg_s;
        cy_d                   = seg_cout;
        if (k_q == K_LAST) begin
          k_d         = '0;
          cout_d      = seg_cout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cy_q        <= 1'b0;
      s_reg_q     <= '0;
      c_reg_q     <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cy_q        <= cy_d;
      s_reg_q     <= s_reg_d;
      c_reg_q     <= c_reg_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/csa_resolve_adder.md
# csa_resolve_adder

Sequential carry-propagate adder that turns a 64-bit carry-save pair (sum vector, carry vector) into a final binary result. It is the consumer end of the carry-save compression tree in the multiplier datapath: the compressor produces the redundant (S, C) pair, and this block resolves it. The block works one SEG-bit segment per cycle with a registered carry. It uses a valid/ready handshake on both sides, so the final addition can be time-multiplexed instead of built as a 64-bit ripple.

## Interface
- WIDTH, 64, operand and result width; must be a multiple of SEG
- SEG, 16, bits resolved per cycle; NSEG = WIDTH/SEG segment cycles per operation
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair
- s_in  in  WIDTH  carry-save sum vector
- c_in  in  WIDTH  carry-save carry vector, already aligned (bit 0 is normally 0)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- sum  out  WIDTH  (s_in + c_in) mod 2^WIDTH
- carry_out  out  1  bit WIDTH of s_in + c_in

## Operation
- State machine states: IDLE, RUN, DONE. The state enum lives in the shared package.
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; segment counter and carry flop clear.
  - sum = 0, carry_out = 0, out_valid = 0.
  - in_ready = 0 while rst_n is low.
- in_ready = 1 exactly when state is IDLE and rst_n is high. in_ready is decoded from state only; it has no combinational path from in_valid or out_ready.
- IDLE:
  - On in_valid & in_ready, register s_in and c_in into operand registers, clear the carry flop and counter k, and go to RUN.
  - s_in/c_in are not sampled at any other time.
- RUN, one segment per edge:
  - {cy, sum[k*SEG +: SEG]} = s_reg[k*SEG +: SEG] + c_reg[k*SEG +: SEG] + carry flop.
  - The carry flop takes cy; k increments.
  - After segment NSEG-1: carry_out = cy, out_valid = 1, state goes to DONE.
- DONE:
  - sum, carry_out and out_valid hold steady while out_ready = 0.
  - On out_ready = 1: out_valid goes to 0, state goes to IDLE.
  - sum and carry_out keep their last values until overwritten by the next operation.
- in_valid during RUN or DONE is ignored; the upstream must hold its data until in_ready is seen.
- Width rules:
  - Segment addition is SEG+1 bits wide.
  - The counter is $clog2(NSEG) bits wide (minimum 1).
  - Overflow beyond bit WIDTH cannot occur: two WIDTH-bit operands sum to at most WIDTH+1 bits.
- During RUN, sum is only partially updated. It is defined only while out_valid = 1.
- Reset in RUN or DONE aborts the operation. The result is discarded and out_valid is never raised for that operation.
- SEG = WIDTH is legal: NSEG = 1 and RUN lasts one cycle.

## Timing
- Accept edge T: the in_valid & in_ready handshake occurs.
- out_valid rises after edge T+NSEG. Latency is NSEG cycles; the default is 4.
- out_valid falls on the first edge where out_ready = 1. in_ready rises in that same cycle.
- Peak throughput is one operation per NSEG+2 cycles: accept, NSEG segment edges, and the DONE handshake.
- After rst_n is released at edge R, in_ready is 1 in the cycle following R.

## Structure
- Package csa_resolve_pkg:
  - state enum (IDLE, RUN, DONE)
  - defaults: WIDTH = 64, SEG = 16
- Sub-module cpa_segment: a purely combinational SEG-bit adder.
  - inputs a, b, cin; outputs s, cout
  - instantiated once and driven through a k-indexed mux
- Top level: FSM, counter, operand registers, carry flop, result register.
- Elaboration check: fail if WIDTH % SEG != 0.

## Test plan
- Reset: hold rst_n low for 2 cycles with in_valid = 1.
  - Required: in_ready = 0, out_valid = 0, sum = 0, carry_out = 0 during reset.
  - Required: in_ready = 1 one cycle after release, and nothing was accepted.
- Cross-segment carry: s_in = 0x0000_0000_0000_FFFF, c_in = 0x1.
  - Required: sum = 0x0000_0000_0001_0000, carry_out = 0.
  - Required: out_valid rises exactly 4 cycles after the accept edge.
- Full ripple: s_in = 0xFFFF_FFFF_FFFF_FFFF, c_in = 0x1.
  - Required: sum = 0, carry_out = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after a result, with in_valid = 1 throughout.
  - Required: out_valid, sum and carry_out stay stable, and in_ready = 0.
  - Required: the new operand is accepted only after the out_ready handshake.
- Reset mid-operation: assert rst_n low while k = 2.
  - Required: out_valid never rises for that operation.
  - Required: the next operation (s_in = 0x5, c_in = 0xA) returns sum = 0xF.
- Random regression: 1000 random (s_in, c_in) pairs with random in_valid and out_ready.
  - Required: every {carry_out, sum} equals s_in + c_in computed to 65 bits.
  - Repeat with SEG = 8 and with SEG = 64.
